load_store_unit: RTL

Memory-stage initiator for the data memory port: converts a RISC-V load/store (funct3, byte address, rs2 data) into word-aligned memory requests with byte enables, then aligns and sign/zero-extends read data. Misaligned halfword/word accesses are split into two consecutive word accesses, stalling the pipeline for one cycle. Sits between the EX/MEM pipeline register and the data memory, which has a synchronous write, an asynchronous read, and ignores address bits [1:0].

---
 rtl/load_store_unit_pkg.sv | 35 +++
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit_load_extend.sv | 26 ++
 rtl/load_store_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, split FSM states and
// helpers that decode access size and legality.
package lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic {
      LSU_IDLE  = 1'b0,
      LSU_SPLIT = 1'b1
   } lsu_state_t;

   // Byte mask of an access before it is shifted to its lane offset.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   // Unsigned variants exist only for loads.
   function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
      case (funct3)
         LSU_B, LSU_H, LSU_W: funct3_legal = 1'b1;
         LSU_BU, LSU_HU:      funct3_legal = !is_store;
         default:             funct3_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-stage bundle: pipeline request/response plus the data memory port.
// master is the load/store unit's view, slave is the pipeline and memory side.
interface load_store_unit_if;
   logic        valid;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        stall;
   logic        load_valid;
   logic [31:0] load_data;
   logic        misaligned;
   logic        illegal;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_read_data;

   modport master (
      input  valid, is_store, funct3, addr, store_data, mem_read_data,
      output stall, load_valid, load_data, misaligned, illegal,
             mem_write_en, mem_addr, mem_write_data, mem_byte_en
   );

   modport slave (
      output valid, is_store, funct3, addr, store_data, mem_read_data,
      input  stall, load_valid, load_data, misaligned, illegal,
             mem_write_en, mem_addr, mem_write_data, mem_byte_en
   );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Extracts a load result from a 64-bit read window at a byte offset and applies
// sign or zero extension; serves both aligned and split loads.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [63:0] window,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] lane;

   always_comb begin
      lane = 32'(window >> {off, 3'b000});
      case (funct3)
         LSU_B:   data = {{24{lane[7]}}, lane[7:0]};
         LSU_H:   data = {{16{lane[15]}}, lane[15:0]};
         LSU_W:   data = lane;
         LSU_BU:  data = {24'd0, lane[7:0]};
         LSU_HU:  data = {16'd0, lane[15:0]};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage initiator: word-aligned requests with byte enables, misaligned
// accesses split across two consecutive words with a one-cycle stall.
//
//   state     | meaning
//   LSU_IDLE  | single access, or first word of a misaligned access
//   LSU_SPLIT | second word of a misaligned access
module load_store_unit
   import lsu_pkg::*;
#(
   parameter bit SUPPORT_MISALIGNED = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   load_store_unit_if.master       bus
);

   lsu_state_t  state, state_nxt;
   logic [31:0] lo_buf;
   logic        capture_lo;

   logic [1:0]  off;
   logic [7:0]  full;
   logic        legal;
   logic        misal;
   logic [31:0] word_addr;
   logic [4:0]  lo_shift;
   logic [5:0]  hi_shift;
   logic [63:0] ld_window;
   logic [31:0] ext_data;
   logic        ld_valid;

   assign off       = bus.addr[1:0];
   assign full      = 8'({4'b0000, size_mask(bus.funct3[1:0])} << off);
   assign legal     = funct3_legal(bus.funct3, bus.is_store);
   assign misal     = |full[7:4];
   assign word_addr = {bus.addr[31:2], 2'b00};
   assign lo_shift  = {off, 3'b000};
   assign hi_shift  = 6'd32 - {1'b0, off, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= LSU_IDLE;
         lo_buf <= '0;
      end else begin
         state <= state_nxt;
         if (capture_lo) begin
            lo_buf <= bus.mem_read_data;
         end
      end
   end

   // Outputs are forced low while reset is held, even mid-split.
   always_comb begin
      state_nxt          = state;
      capture_lo         = 1'b0;
      ld_valid           = 1'b0;
      ld_window          = '0;
      bus.stall          = 1'b0;
      bus.misaligned     = 1'b0;
      bus.illegal        = 1'b0;
      bus.mem_write_en   = 1'b0;
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;
      bus.mem_byte_en    = '0;
      if (rst_n) begin
         case (state)
            LSU_IDLE: begin
               if (bus.valid) begin
                  if (!legal) begin
                     bus.illegal = 1'b1;
                  end else if (misal && !SUPPORT_MISALIGNED) begin
                     bus.misaligned = 1'b1;
                  end else begin
                     bus.mem_addr       = word_addr;
                     bus.mem_byte_en    = full[3:0];
                     bus.mem_write_data = bus.store_data << lo_shift;
                     bus.mem_write_en   = bus.is_store;
                     if (!misal) begin
                        ld_valid  = !bus.is_store;
                        ld_window = {32'd0, bus.mem_read_data};
                     end else begin
                        bus.stall  = 1'b1;
                        capture_lo = !bus.is_store;
                        state_nxt  = LSU_SPLIT;
                     end
                  end
               end
            end
            LSU_SPLIT: begin
               state_nxt = LSU_IDLE;
               // Dropping valid here aborts the second half.
               if (bus.valid && legal) begin
                  bus.mem_addr       = word_addr + 32'd4;
                  bus.mem_byte_en    = full[7:4];
                  bus.mem_write_data = bus.store_data >> hi_shift;
                  bus.mem_write_en   = bus.is_store;
                  ld_valid           = !bus.is_store;
                  ld_window          = {bus.mem_read_data, lo_buf};
               end
            end
            default: state_nxt = LSU_IDLE;
         endcase
      end
   end

   lsu_load_extend u_load_extend (
      .window (ld_window),
      .off    (off),
      .funct3 (bus.funct3),
      .data   (ext_data)
   );

   assign bus.load_valid = ld_valid;
   assign bus.load_data  = ld_valid ? ext_data : 32'd0;

endmodule
